// File: rtl/orga_pkg.sv
// orga_pkg: definitions shared by the OrgaSmall instruction decoder and the
// program loader. It holds the instruction field widths, the format
// enumeration and the bit positions of each field inside the 16-bit word.
package orga_pkg;

  localparam int unsigned INST_SIZE     = 16;
  localparam int unsigned OPCODE_BITS   = 5;
  localparam int unsigned REGISTER_BITS = 3;
  localparam int unsigned IMM_BITS      = 8;

  typedef enum logic {
    FMT_REG = 1'b0,
    FMT_IMM = 1'b1
  } fmt_e;

  // Field positions inside the instruction word.
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 11;
  localparam int unsigned RX_MSB     = 10;
  localparam int unsigned RX_LSB     = 8;
  localparam int unsigned RY_MSB     = 7;
  localparam int unsigned RY_LSB     = 5;
  localparam int unsigned IMM_MSB    = 7;
  localparam int unsigned IMM_LSB    = 0;

endpackage

// File: rtl/program_loader_inst_encoder.sv
// inst_encoder: purely combinational packer that turns instruction fields
// into a 16-bit OrgaSmall instruction word. It is the inverse of the decoder.
// Ports:
//   fmt_i    : 0 = register format {opcode, rx, ry, 5'b0}
//              1 = immediate format {opcode, rx, imm}
//   opcode_i : opcode field
//   rx_i     : destination register
//   ry_i     : source register (register format only)
//   imm_i    : immediate (immediate format only)
//   word_o   : packed instruction word
module inst_encoder
  import orga_pkg::*;
(
  input  logic                     fmt_i,
  input  logic [OPCODE_BITS-1:0]   opcode_i,
  input  logic [REGISTER_BITS-1:0] rx_i,
  input  logic [REGISTER_BITS-1:0] ry_i,
  input  logic [IMM_BITS-1:0]      imm_i,
  output logic [INST_SIZE-1:0]     word_o
);

  always_comb begin
    word_o = '0;
    word_o[OPCODE_MSB:OPCODE_LSB] = opcode_i;
    word_o[RX_MSB:RX_LSB]         = rx_i;
    if (fmt_e'(fmt_i) == FMT_IMM) begin
      word_o[IMM_MSB:IMM_LSB] = imm_i;
    end else begin
      word_o[RY_MSB:RY_LSB] = ry_i;
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: accepts instruction fields over a valid/ready handshake,
// packs them into a 16-bit word and writes it as two bytes (high byte first)
// into byte-wide program memory at an auto-incrementing address.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : restart loading at BASE_ADDR; clears count/overflow
//   in_valid/in_ready : instruction handshake
//   in_fmt, in_opcode, in_rx, in_ry, in_imm : instruction fields
//   mem_we/mem_ready  : byte write request / memory accept
//   mem_addr, mem_wdata : byte address and data
//   inst_count        : instructions fully written since reset/start
//   overflow          : sticky; address pointer wrapped past all-ones
//   checksum          : (LOADER_CHECKSUM_EN only) mod-256 sum of committed bytes
// Optional feature macro: LOADER_CHECKSUM_EN
module program_loader
  import orga_pkg::*;
#(
  parameter int unsigned           ADDR_BITS = 8,
  parameter logic [ADDR_BITS-1:0]  BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_fmt,
  input  logic [OPCODE_BITS-1:0]   in_opcode,
  input  logic [REGISTER_BITS-1:0] in_rx,
  input  logic [REGISTER_BITS-1:0] in_ry,
  input  logic [IMM_BITS-1:0]      in_imm,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic [ADDR_BITS-1:0]     mem_addr,
  output logic [7:0]               mem_wdata,
  output logic [ADDR_BITS-1:0]     inst_count,
`ifdef LOADER_CHECKSUM_EN
  output logic [7:0]               checksum,
`endif
  output logic                     overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_e;

  state_e                 state_q;
  logic [ADDR_BITS-1:0]   ptr_q;
  logic [ADDR_BITS-1:0]   ptr_d;
  logic                   wrap_d;
  logic [INST_SIZE-1:0]   word_q;
  logic [INST_SIZE-1:0]   word_d;
  logic [ADDR_BITS-1:0]   count_q;
  logic                   ovf_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             sum_q;
`endif

  inst_encoder u_enc (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rx_i     (in_rx),
    .ry_i     (in_ry),
    .imm_i    (in_imm),
    .word_o   (word_d)
  );

  assign ptr_d  = ptr_q + ADDR_BITS'(1);
  assign wrap_d = &ptr_q;

  // Outputs depend only on registered state, never directly on inputs.
  assign mem_we     = (state_q != IDLE);
  assign mem_addr   = ptr_q;
  assign mem_wdata  = (state_q == LO) ? word_q[7:0] : word_q[INST_SIZE-1:8];
  assign in_ready   = (state_q == IDLE) && !ovf_q;
  assign inst_count = count_q;
  assign overflow   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum   = sum_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= BASE_ADDR;
      word_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else if (start) begin
      // start wins over any handshake or pending byte write this cycle.
      state_q <= IDLE;
      ptr_q   <= BASE_ADDR;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
`ifdef LOADER_CHECKSUM_EN
      if (mem_we && mem_ready) begin
        sum_q <= sum_q + mem_wdata;
      end
`endif
      unique case (state_q)
        IDLE: begin
          if (in_valid && !ovf_q) begin
            word_q  <= word_d;
            state_q <= HI;
          end
        end
        HI: begin
          if (mem_ready) begin
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_q | wrap_d;
            state_q <= LO;
          end
        end
        LO: begin
          if (mem_ready) begin
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_q | wrap_d;
            count_q <= count_q + ADDR_BITS'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 0x00 and base 0xFE) share the
// same stimulus. A per-instance scoreboard model predicts every output each
// cycle; directed literal checks pin specific expected bytes and addresses.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_fmt = 1'b0;
  logic [4:0] in_opcode = '0;
  logic [2:0] in_rx = '0;
  logic [2:0] in_ry = '0;
  logic [7:0] in_imm = '0;
  logic       mem_ready = 1'b1;

  logic       rdy  [2];
  logic       we   [2];
  logic [7:0] addr [2];
  logic [7:0] wdat [2];
  logic [7:0] cnt  [2];
  logic [7:0] cks  [2];
  logic       ovf  [2];

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  program_loader #(.ADDR_BITS(8), .BASE_ADDR(8'h00)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (rdy[0]),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rx      (in_rx),
    .in_ry      (in_ry),
    .in_imm     (in_imm),
    .mem_we     (we[0]),
    .mem_ready  (mem_ready),
    .mem_addr   (addr[0]),
    .mem_wdata  (wdat[0]),
    .inst_count (cnt[0]),
`ifdef LOADER_CHECKSUM_EN
    .checksum   (cks[0]),
`endif
    .overflow   (ovf[0])
  );

  program_loader #(.ADDR_BITS(8), .BASE_ADDR(8'hFE)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (rdy[1]),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rx      (in_rx),
    .in_ry      (in_ry),
    .in_imm     (in_imm),
    .mem_we     (we[1]),
    .mem_ready  (mem_ready),
    .mem_addr   (addr[1]),
    .mem_wdata  (wdat[1]),
    .inst_count (cnt[1]),
`ifdef LOADER_CHECKSUM_EN
    .checksum   (cks[1]),
`endif
    .overflow   (ovf[1])
  );

`ifndef LOADER_CHECKSUM_EN
  assign cks[0] = '0;
  assign cks[1] = '0;
`endif

  // ---------------- behavioural model ----------------
  int unsigned base   [2] = '{0, 254};
  int unsigned m_ptr  [2];
  int unsigned m_cnt  [2];
  int unsigned m_pend [2];   // bytes of current instruction still to write
  int unsigned m_sum  [2];
  int unsigned m_hi   [2];
  int unsigned m_lo   [2];
  int unsigned m_last [2];   // high byte of the most recently accepted word
  bit          m_ovf  [2];

  function automatic int unsigned encode();
    int unsigned w;
    w = int'(in_opcode) * 2048 + int'(in_rx) * 256;
    if (in_fmt) w = w + int'(in_imm);
    else        w = w + int'(in_ry) * 32;
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ptr[i] = base[i]; m_cnt[i] = 0; m_pend[i] = 0; m_sum[i] = 0;
        m_hi[i] = 0; m_lo[i] = 0; m_last[i] = 0; m_ovf[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start) begin
          m_ptr[i] = base[i]; m_cnt[i] = 0; m_pend[i] = 0;
          m_sum[i] = 0; m_ovf[i] = 1'b0;
        end else if (m_pend[i] > 0) begin
          if (mem_ready) begin
            m_sum[i] = (m_sum[i] + ((m_pend[i] == 2) ? m_hi[i] : m_lo[i])) % 256;
            if (m_ptr[i] == 255) m_ovf[i] = 1'b1;
            m_ptr[i] = (m_ptr[i] + 1) % 256;
            m_pend[i] = m_pend[i] - 1;
            if (m_pend[i] == 0) m_cnt[i] = (m_cnt[i] + 1) % 256;
          end
        end else if (in_valid && !m_ovf[i]) begin
          m_hi[i]   = encode() / 256;
          m_lo[i]   = encode() % 256;
          m_last[i] = m_hi[i];
          m_pend[i] = 2;
        end
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int unsigned exp_data;
      exp_data = (m_pend[i] == 1) ? m_lo[i] : m_last[i];
      chk($sformatf("m%0d_we", i),    we[i],   (m_pend[i] > 0) ? 1 : 0);
      chk($sformatf("m%0d_addr", i),  addr[i], m_ptr[i]);
      chk($sformatf("m%0d_wdata", i), wdat[i], exp_data);
      chk($sformatf("m%0d_ready", i), rdy[i],  (m_pend[i] == 0 && !m_ovf[i]) ? 1 : 0);
      chk($sformatf("m%0d_count", i), cnt[i],  m_cnt[i]);
      chk($sformatf("m%0d_ovf", i),   ovf[i],  m_ovf[i]);
`ifdef LOADER_CHECKSUM_EN
      chk($sformatf("m%0d_cks", i),   cks[i],  m_sum[i]);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry);
    in_fmt = 1'b0; in_opcode = op; in_rx = rx; in_ry = ry; in_imm = 8'hC3;
  endtask

  task automatic set_imm(input logic [4:0] op, input logic [2:0] rx, input logic [7:0] imm,
                         input logic [2:0] ry);
    in_fmt = 1'b1; in_opcode = op; in_rx = rx; in_imm = imm; in_ry = ry;
  endtask

  initial begin
    // Reset values.
    cyc(); cyc();
    chk("rst_we0", we[0], 0);
    chk("rst_addr0", addr[0], 8'h00);
    chk("rst_addr1", addr[1], 8'hFE);
    chk("rst_wdata0", wdat[0], 8'h00);
    chk("rst_ready0", rdy[0], 1);
    chk("rst_cnt0", cnt[0], 0);
    rst_n = 1'b1;
    cyc();

    // Register format: 0x8BA0.
    set_reg(5'b10001, 3'd3, 3'd5);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("a_hi_we", we[0], 1);
    chk("a_hi_addr", addr[0], 8'h00);
    chk("a_hi_data", wdat[0], 8'h8B);
    chk("a_hi_ready", rdy[0], 0);
    chk("a_hi_addr1", addr[1], 8'hFE);
    chk("model_hi", m_hi[0], 8'h8B);
    cyc();
    chk("a_lo_addr", addr[0], 8'h01);
    chk("a_lo_data", wdat[0], 8'hA0);
    chk("model_lo", m_lo[0], 8'hA0);
    cyc();
    chk("a_done_we", we[0], 0);
    chk("a_done_cnt", cnt[0], 1);
    chk("a_done_ready", rdy[0], 1);
    chk("wrap_ovf1", ovf[1], 1);
    chk("wrap_ready1", rdy[1], 0);
    chk("wrap_addr1", addr[1], 8'h00);
`ifdef LOADER_CHECKSUM_EN
    chk("a_cks0", cks[0], 8'h2B);
`endif

    // Immediate format: 0xA27F; ry is ignored. Overflowed instance refuses it.
    set_imm(5'b10100, 3'd2, 8'h7F, 3'd7);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("b_hi_addr", addr[0], 8'h02);
    chk("b_hi_data", wdat[0], 8'hA2);
    chk("b_refused_we1", we[1], 0);
    cyc();
    chk("b_lo_addr", addr[0], 8'h03);
    chk("b_lo_data", wdat[0], 8'h7F);
    cyc();
    chk("b_cnt0", cnt[0], 2);
    chk("b_cnt1", cnt[1], 1);

    // mem_ready low for four HI cycles: 0x0F20, fields scrambled after accept.
    set_reg(5'b00001, 3'd7, 3'd1);
    in_valid = 1'b1;
    mem_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    set_imm(5'b11111, 3'd5, 8'h99, 3'd2);
    for (int k = 0; k < 4; k++) begin
      chk("c_hold_addr", addr[0], 8'h04);
      chk("c_hold_data", wdat[0], 8'h0F);
      if (k < 3) cyc();
    end
    mem_ready = 1'b1;
    cyc();
    chk("c_lo_addr", addr[0], 8'h05);
    chk("c_lo_data", wdat[0], 8'h20);
    cyc();
    chk("c_cnt0", cnt[0], 3);

    // start during LO abandons the instruction and clears overflow.
    set_reg(5'b10001, 3'd3, 3'd5);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("d_lo_we", we[0], 1);
    chk("d_lo_addr", addr[0], 8'h07);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("d_start_we", we[0], 0);
    chk("d_start_addr", addr[0], 8'h00);
    chk("d_start_cnt", cnt[0], 0);
    chk("d_start_ovf1", ovf[1], 0);
    chk("d_start_addr1", addr[1], 8'hFE);
`ifdef LOADER_CHECKSUM_EN
    chk("d_start_cks0", cks[0], 8'h00);
`endif

    // start together with a handshake: instruction not accepted.
    set_imm(5'b00011, 3'd1, 8'h55, 3'd0);
    in_valid = 1'b1;
    start = 1'b1;
    cyc();
    in_valid = 1'b0;
    start = 1'b0;
    chk("e_no_accept_we0", we[0], 0);
    chk("e_no_accept_we1", we[1], 0);

    // Back-to-back throughput with in_valid held high.
    set_imm(5'b01010, 3'd4, 8'h3C, 3'd0);
    in_valid = 1'b1;
    repeat (7) cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("f_cnt0", cnt[0], 3);

    // Asynchronous reset in the middle of a write.
    set_reg(5'b00110, 3'd6, 3'd6);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("g_arst_we0", we[0], 0);
    chk("g_arst_we1", we[1], 0);
    chk("g_arst_addr0", addr[0], 8'h00);
    chk("g_arst_cnt0", cnt[0], 0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
